// File: rtl/pmem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pmem_arbiter                                                             |
// | Shares one physical-memory line port between icache and dcache: one     |
// | transaction at a time, latched request, response routed to the winner.  |
// | Optional feature macro: PMEM_ARB_RR_EN (round-robin tie-break).          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              icache_pmem_read,
  input  logic [ADDR_W-1:0] icache_pmem_address,
  output logic [LINE_W-1:0] icache_pmem_rdata,
  output logic              icache_pmem_resp,

  input  logic              dcache_pmem_read,
  input  logic              dcache_pmem_write,
  input  logic [ADDR_W-1:0] dcache_pmem_address,
  input  logic [LINE_W-1:0] dcache_pmem_wdata,
  output logic [LINE_W-1:0] dcache_pmem_rdata,
  output logic              dcache_pmem_resp,

  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,

  output logic              arb_busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVE_I = 2'd1,
    ST_SERVE_D = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic              r_dir;
  logic              r_last;

  logic              w_req_i;
  logic              w_req_d;
  logic              w_tie_d;
  logic              w_grant_i;
  logic              w_grant_d;

  assign w_req_i = icache_pmem_read;
  assign w_req_d = dcache_pmem_read | dcache_pmem_write;

`ifdef PMEM_ARB_RR_EN
  // Tie goes to whichever side did not win last time.
  assign w_tie_d = ~r_last;
`else
  logic w_unused_last;
  assign w_unused_last = r_last;
  assign w_tie_d       = 1'b1;
`endif

  assign w_grant_d = w_req_d & (~w_req_i | w_tie_d);
  assign w_grant_i = w_req_i & ~w_grant_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_dir   <= 1'b0;
      r_last  <= 1'b1;
    end else if (r_state == ST_IDLE) begin
      if (w_grant_d) begin
        r_addr  <= dcache_pmem_address;
        r_wdata <= dcache_pmem_wdata;
        r_dir   <= dcache_pmem_write;
        r_last  <= 1'b1;
      end else if (w_grant_i) begin
        r_addr  <= icache_pmem_address;
        r_last  <= 1'b0;
      end
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    icache_pmem_resp = 1'b0;
    dcache_pmem_resp = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_d) begin
          w_state_nxt = ST_SERVE_D;
        end else if (w_grant_i) begin
          w_state_nxt = ST_SERVE_I;
        end
      end
      ST_SERVE_I: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          icache_pmem_resp = 1'b1;
          w_state_nxt      = ST_RELEASE;
        end
      end
      ST_SERVE_D: begin
        pmem_read  = ~r_dir;
        pmem_write = r_dir;
        if (pmem_resp) begin
          dcache_pmem_resp = 1'b1;
          w_state_nxt      = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Read data is broadcast; the per-cache resp strobe is the only qualifier.
  assign icache_pmem_rdata = pmem_rdata;
  assign dcache_pmem_rdata = pmem_rdata;
  assign pmem_address      = r_addr;
  assign pmem_wdata        = r_wdata;
  assign arb_busy          = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pmem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pmem_arbiter                                                          |
// | Vector table plus scoreboard bench for pmem_arbiter.                     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pmem_arbiter;
  localparam int AW = 16;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          icache_pmem_read = 1'b0;
  logic [AW-1:0] icache_pmem_address = '0;
  logic [LW-1:0] icache_pmem_rdata;
  logic          icache_pmem_resp;
  logic          dcache_pmem_read = 1'b0;
  logic          dcache_pmem_write = 1'b0;
  logic [AW-1:0] dcache_pmem_address = '0;
  logic [LW-1:0] dcache_pmem_wdata = '0;
  logic [LW-1:0] dcache_pmem_rdata;
  logic          dcache_pmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata = '0;
  logic          pmem_resp;
  logic          arb_busy;

  always #5 clk = ~clk;

  pmem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .icache_pmem_read    (icache_pmem_read),
    .icache_pmem_address (icache_pmem_address),
    .icache_pmem_rdata   (icache_pmem_rdata),
    .icache_pmem_resp    (icache_pmem_resp),
    .dcache_pmem_read    (dcache_pmem_read),
    .dcache_pmem_write   (dcache_pmem_write),
    .dcache_pmem_address (dcache_pmem_address),
    .dcache_pmem_wdata   (dcache_pmem_wdata),
    .dcache_pmem_rdata   (dcache_pmem_rdata),
    .dcache_pmem_resp    (dcache_pmem_resp),
    .pmem_read           (pmem_read),
    .pmem_write          (pmem_write),
    .pmem_address        (pmem_address),
    .pmem_wdata          (pmem_wdata),
    .pmem_rdata          (pmem_rdata),
    .pmem_resp           (pmem_resp),
    .arb_busy            (arb_busy)
  );

  typedef struct {
    logic          rd;
    logic          wr;
    logic          is_d;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
    int            delay;
  } exp_t;

  typedef struct {
    logic          i_rd;
    logic          d_rd;
    logic          d_wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
    int            delay;
    logic          exp_rd;
    logic          exp_wr;
    logic          exp_d;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Memory model: responds in the mem_delay-th cycle of an asserted strobe.
  int   mem_delay = 1;
  int   mem_cnt   = 0;
  logic mem_resp  = 1'b0;
  logic spur      = 1'b0;
  assign pmem_resp = mem_resp | spur;

  initial forever begin
    @(posedge clk);
    #2;
    if (pmem_read | pmem_write) begin
      mem_cnt++;
      mem_resp = (mem_cnt == mem_delay);
    end else begin
      mem_cnt  = 0;
      mem_resp = 1'b0;
    end
  end

  // Monitor: pops an expectation at each new grant, checks it through to resp.
  exp_t cur;
  bit   active = 1'b0;
  bit   prev   = 1'b0;
  int   ncyc   = 0;
  logic strobe;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      active = 1'b0;
      prev   = 1'b0;
    end else begin
      strobe = pmem_read | pmem_write;
      if (strobe && !prev) begin
        chk("grant_has_expectation", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          cur    = sb.pop_front();
          active = 1'b1;
          ncyc   = 0;
          chk("grant_rd", pmem_read, cur.rd);
          chk("grant_wr", pmem_write, cur.wr);
        end
      end
      if (strobe && active) begin
        ncyc++;
        chk("addr_hold", pmem_address, cur.addr);
        if (cur.wr) chk("wdata_hold", pmem_wdata, cur.wdata);
      end
      if (icache_pmem_resp | dcache_pmem_resp) begin
        chk("resp_in_serve", active, 1);
        if (active) begin
          chk("resp_to_d", dcache_pmem_resp, cur.is_d);
          chk("resp_to_i", icache_pmem_resp, !cur.is_d);
          chk("resp_rdata", cur.is_d ? dcache_pmem_rdata : icache_pmem_rdata, cur.rdata);
          chk("resp_cycles", ncyc, cur.delay);
          active = 1'b0;
        end
      end
      prev = strobe;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drop_all();
    icache_pmem_read  = 1'b0;
    dcache_pmem_read  = 1'b0;
    dcache_pmem_write = 1'b0;
  endtask

  // Returns two time units into the RELEASE cycle.
  task automatic wait_resp();
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (icache_pmem_resp | dcache_pmem_resp) seen = 1'b1;
    end
    chk("resp_seen", seen, 1);
    tick();
  endtask

  task automatic check_release();
    @(negedge clk);
    chk("release_busy", arb_busy, 1);
    chk("release_strobes", {pmem_read, pmem_write}, 0);
    tick();
    @(negedge clk);
    chk("idle_busy", arb_busy, 0);
  endtask

  task automatic push(input logic rd, input logic wr, input logic is_d, input logic [AW-1:0] addr,
                      input logic [LW-1:0] wdata, input logic [LW-1:0] rdata, input int delay);
    exp_t e;
    e.rd = rd; e.wr = wr; e.is_d = is_d; e.addr = addr;
    e.wdata = wdata; e.rdata = rdata; e.delay = delay;
    sb.push_back(e);
  endtask

  vec_t vecs[5];
  bit   tie_d[5];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{i_rd:1'b1, d_rd:1'b0, d_wr:1'b0, addr:16'h1230, wdata:'0,
                rdata:{16{8'hA5}}, delay:3, exp_rd:1'b1, exp_wr:1'b0, exp_d:1'b0};
    vecs[1] = '{i_rd:1'b0, d_rd:1'b0, d_wr:1'b1, addr:16'h4000,
                wdata:128'h0123456789ABCDEF0123456789ABCDEF,
                rdata:{16{8'h11}}, delay:2, exp_rd:1'b0, exp_wr:1'b1, exp_d:1'b1};
    vecs[2] = '{i_rd:1'b0, d_rd:1'b1, d_wr:1'b0, addr:16'h4010, wdata:{16{8'hCC}},
                rdata:{16{8'h5A}}, delay:1, exp_rd:1'b1, exp_wr:1'b0, exp_d:1'b1};
    vecs[3] = '{i_rd:1'b0, d_rd:1'b1, d_wr:1'b1, addr:16'h4020,
                wdata:128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0,
                rdata:{16{8'h22}}, delay:2, exp_rd:1'b0, exp_wr:1'b1, exp_d:1'b1};
    vecs[4] = '{i_rd:1'b1, d_rd:1'b0, d_wr:1'b0, addr:16'hFFF0, wdata:'0,
                rdata:128'hFEDCBA98_76543210_0F1E2D3C_4B5A6978, delay:5,
                exp_rd:1'b1, exp_wr:1'b0, exp_d:1'b0};
`ifdef PMEM_ARB_RR_EN
    tie_d = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
    tie_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`endif

    // Async reset: outputs clear before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_read", pmem_read, 0);
    chk("rst_write", pmem_write, 0);
    chk("rst_addr", pmem_address, 0);
    chk("rst_wdata", pmem_wdata, 0);
    chk("rst_busy", arb_busy, 0);
    chk("rst_resps", {icache_pmem_resp, dcache_pmem_resp}, 0);
    icache_pmem_read = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_hold_read", pmem_read, 0);
    drop_all();
    tick();
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      tick();
      icache_pmem_read    = vecs[v].i_rd;
      dcache_pmem_read    = vecs[v].d_rd;
      dcache_pmem_write   = vecs[v].d_wr;
      icache_pmem_address = vecs[v].i_rd ? vecs[v].addr : ~vecs[v].addr;
      dcache_pmem_address = vecs[v].i_rd ? ~vecs[v].addr : vecs[v].addr;
      dcache_pmem_wdata   = vecs[v].wdata;
      pmem_rdata          = vecs[v].rdata;
      mem_delay           = vecs[v].delay;
      push(vecs[v].exp_rd, vecs[v].exp_wr, vecs[v].exp_d, vecs[v].addr,
           vecs[v].wdata, vecs[v].rdata, vecs[v].delay);
      @(negedge clk);
      chk("grant_latency_idle", arb_busy, 0);
      wait_resp();
      drop_all();
      check_release();
    end

    // Both requesters held: grant order depends on tie-break mode.
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    icache_pmem_read    = 1'b1;
    icache_pmem_address = 16'h1100;
    dcache_pmem_read    = 1'b1;
    dcache_pmem_address = 16'h2200;
    pmem_rdata          = {8{16'hBEEF}};
    mem_delay           = 2;
    for (int k = 0; k < 5; k++)
      push(1'b1, 1'b0, tie_d[k], tie_d[k] ? 16'h2200 : 16'h1100, '0, {8{16'hBEEF}}, 2);
    for (int k = 0; k < 5; k++) begin
      wait_resp();
      if (k == 3) dcache_pmem_read = 1'b0;
      if (k == 4) drop_all();
    end
    check_release();

    // Address change during service is ignored.
    tick();
    dcache_pmem_read    = 1'b1;
    dcache_pmem_address = 16'h2000;
    pmem_rdata          = {4{32'h600DF00D}};
    mem_delay           = 4;
    push(1'b1, 1'b0, 1'b1, 16'h2000, '0, {4{32'h600DF00D}}, 4);
    tick();
    tick();
    dcache_pmem_address = 16'h3000;
    wait_resp();
    drop_all();
    check_release();

    // Reset between edges during a dcache write abandons it.
    begin
      bit started = 1'b0;
      tick();
      dcache_pmem_write   = 1'b1;
      dcache_pmem_address = 16'h6000;
      dcache_pmem_wdata   = {4{32'hA1B2C3D4}};
      mem_delay           = 10;
      push(1'b0, 1'b1, 1'b1, 16'h6000, {4{32'hA1B2C3D4}}, '0, 10);
      for (int i = 0; i < 20 && !started; i++) begin
        @(negedge clk);
        if (pmem_write) started = 1'b1;
      end
      chk("rst_txn_started", started, 1);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("rst_mid_write", pmem_write, 0);
      chk("rst_mid_busy", arb_busy, 0);
      chk("rst_mid_addr", pmem_address, 0);
      chk("rst_mid_wdata", pmem_wdata, 0);
      drop_all();
      @(posedge clk);
      #3 rst_n = 1'b1;
    end
    tick();
    icache_pmem_read    = 1'b1;
    icache_pmem_address = 16'h5550;
    pmem_rdata          = {16{8'h3C}};
    mem_delay           = 2;
    push(1'b1, 1'b0, 1'b0, 16'h5550, '0, {16{8'h3C}}, 2);
    wait_resp();
    drop_all();
    check_release();

    // Spurious responses in IDLE and RELEASE.
    tick();
    spur = 1'b1;
    @(negedge clk);
    chk("spur_idle_resps", {icache_pmem_resp, dcache_pmem_resp}, 0);
    chk("spur_idle_busy", arb_busy, 0);
    tick();
    spur = 1'b0;
    @(negedge clk);
    chk("spur_idle_after", arb_busy, 0);

    tick();
    icache_pmem_read    = 1'b1;
    icache_pmem_address = 16'h0040;
    pmem_rdata          = {16{8'h77}};
    mem_delay           = 1;
    push(1'b1, 1'b0, 1'b0, 16'h0040, '0, {16{8'h77}}, 1);
    wait_resp();
    spur = 1'b1;
    drop_all();
    @(negedge clk);
    chk("spur_rel_resps", {icache_pmem_resp, dcache_pmem_resp}, 0);
    chk("spur_rel_busy", arb_busy, 1);
    chk("spur_rel_strobes", {pmem_read, pmem_write}, 0);
    tick();
    spur = 1'b0;
    @(negedge clk);
    chk("spur_rel_idle", arb_busy, 0);

    repeat (3) tick();
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pmem_arbiter.md
# pmem_arbiter

Sequencer and arbiter for the single physical-memory port shared by the instruction cache and the data cache. Sits between the two cache miss/writeback interfaces and the physical memory. Grants one 128-bit line transaction at a time, latches the winning request, holds it on the memory port until `pmem_resp`, and routes the response back to the winning cache only.

## Interface
Parameters:
- `ADDR_W`, default 16: byte address width (`lc3b_word`).
- `LINE_W`, default 128: cache line width in bits.

Ports:
- `clk` input 1: system clock. All state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `icache_pmem_read` input 1: icache line-fill request.
- `icache_pmem_address` input ADDR_W: icache line address.
- `icache_pmem_rdata` output LINE_W: fill data to icache.
- `icache_pmem_resp` output 1: icache transaction complete.
- `dcache_pmem_read` input 1: dcache line-fill request.
- `dcache_pmem_write` input 1: dcache writeback request.
- `dcache_pmem_address` input ADDR_W: dcache line address.
- `dcache_pmem_wdata` input LINE_W: writeback data.
- `dcache_pmem_rdata` output LINE_W: fill data to dcache.
- `dcache_pmem_resp` output 1: dcache transaction complete.
- `pmem_read` output 1: physical memory read strobe.
- `pmem_write` output 1: physical memory write strobe.
- `pmem_address` output ADDR_W: physical memory address.
- `pmem_wdata` output LINE_W: physical memory write data.
- `pmem_rdata` input LINE_W: physical memory read data.
- `pmem_resp` input 1: physical memory transaction complete.
- `arb_busy` output 1: high in any state other than IDLE.

## Operation
- States: IDLE, SERVE_I, SERVE_D, RELEASE.
- IDLE: sample requests. A request is `icache_pmem_read` (I) or `dcache_pmem_read | dcache_pmem_write` (D). None → stay. Only I → SERVE_I. Only D → SERVE_D. Both → winner per Configuration.
- On the grant edge: latch address into `addr_q`. For D, also latch `wdata_q` and direction `dir_q` (1 = write). If D read and write are both high, the transaction is a write.
- SERVE_I: `pmem_read`=1, `pmem_write`=0, `pmem_address`=`addr_q`.
- SERVE_D: `pmem_read`=~`dir_q`, `pmem_write`=`dir_q`, `pmem_address`=`addr_q`, `pmem_wdata`=`wdata_q`.
- Changes on requester inputs while serving are ignored. Requesters must hold until resp, but the arbiter does not depend on it.
- `pmem_resp` in SERVE_X: assert `X_pmem_resp` combinationally in the same cycle, then go to RELEASE on the next edge.
- `pmem_resp` outside SERVE_I/SERVE_D is ignored and never forwarded.
- RELEASE: lasts one cycle with all strobes 0 and requests ignored. This lets the served cache drop its request. Then → IDLE.
- `icache_pmem_rdata` = `dcache_pmem_rdata` = `pmem_rdata` (broadcast). Only the resp line qualifies the data.
- Outputs outside SERVE states: strobes 0; `pmem_address`=`addr_q`; `pmem_wdata`=`wdata_q`.
- `last_q`: records the winner of the most recent grant (0 = I, 1 = D).

## Timing
- Reset (async, `rst_n`=0): state=IDLE, `addr_q`=0, `wdata_q`=0, `dir_q`=0, `last_q`=1. All outputs 0 immediately, without waiting for a clock edge. Asserting reset mid-transaction abandons that transaction.
- Grant latency: request high in IDLE at edge k → SERVE state and memory strobe asserted from cycle k+1.
- Resp: `pmem_resp` high in cycle m → cache resp high in cycle m, RELEASE in m+1, IDLE in m+2.
- The earliest next grant is at the edge ending cycle m+2, so the next strobe appears at m+3.
- `pmem_resp` already high in the first SERVE cycle: the transaction completes in that cycle.
- A single outstanding transaction at all times, with no pipelining.

## Configuration
- `PMEM_ARB_RR_EN` defined: round-robin on ties. The grant goes to the requester that is not `last_q`. After reset `last_q`=1, so the first tie goes to I.
- Undefined: fixed priority. D always wins ties. `last_q` is still maintained but is not used for arbitration.

## Test plan
- Lone icache read, addr 0x1230, memory resp after 3 cycles with rdata 0xA5…A5 → `pmem_read`=1, `pmem_address`=0x1230 for 3 cycles; `icache_pmem_resp` pulses 1 cycle with data; `dcache_pmem_resp` stays 0.
- Lone dcache write, addr 0x4000, wdata 0x0123…EF, resp after 2 cycles → `pmem_write`=1 and `pmem_read`=0, wdata matches; then RELEASE; `arb_busy` low 2 cycles after resp.
- I and D reads raised in the same cycle, held continuously. With RR: I, D, I, D grant order. Without RR: D every time until D drops, then I.
- Requester changes address from 0x2000 to 0x3000 mid-transaction → `pmem_address` stays 0x2000 until resp.
- `rst_n` pulled low in SERVE_D between clock edges → `pmem_write`=0 immediately; after release, a new I request is granted normally.
- Spurious `pmem_resp` in IDLE and in RELEASE → no cache resp and no state change.
